// File: rtl/chorus_ctrl_if.sv
// Sample-stream and delay-line RAM signal bundle for chorus_ctrl.
// master = audio source plus RAM model side, slave = chorus_ctrl.
interface chorus_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     enable;
    logic [15:0]              lfo_step;
    logic [7:0]               depth;
    logic signed [DATA_W-1:0] sample_out;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;
    logic [ADDR_W-1:0]        ram_ada;
    logic signed [DATA_W-1:0] ram_din;
    logic                     ram_cea;
    logic [ADDR_W-1:0]        ram_adb;
    logic                     ram_ceb;
    logic                     ram_oce;
    logic                     ram_reset;
    logic signed [DATA_W-1:0] ram_dout;

    modport master (
        output sample_in, sample_valid, enable, lfo_step, depth, ram_dout,
        input  sample_out, out_valid, busy, overrun,
        input  ram_ada, ram_din, ram_cea, ram_adb, ram_ceb, ram_oce, ram_reset
    );

    modport slave (
        input  sample_in, sample_valid, enable, lfo_step, depth, ram_dout,
        output sample_out, out_valid, busy, overrun,
        output ram_ada, ram_din, ram_cea, ram_adb, ram_ceb, ram_oce, ram_reset
    );
endinterface

// File: rtl/chorus_ctrl.sv
// Chorus delay-line sequencer: writes each sample to a circular RAM buffer, reads an
// LFO-modulated tap and emits the dry/wet mix. Define CHORUS_INTERP_EN for linear tap interpolation.
module chorus_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int BASE_DELAY = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    chorus_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_CAP0 = 3'd2;
`ifdef CHORUS_INTERP_EN
    localparam logic [2:0] S_RD1  = 3'd3;
    localparam logic [2:0] S_CAP1 = 3'd4;
`endif
    localparam logic [2:0] S_MIX  = 3'd5;

    function automatic logic signed [DATA_W-1:0] mix_out(
        input logic                     en,
        input logic signed [DATA_W-1:0] dry,
        input logic signed [DATA_W-1:0] wet
    );
        return en ? (dry >>> 1) + (wet >>> 1) : dry;
    endfunction

`ifdef CHORUS_INTERP_EN
    // Difference kept at DATA_W+1 bits so full-scale opposite-sign taps cannot wrap.
    function automatic logic signed [DATA_W-1:0] interp(
        input logic signed [DATA_W-1:0] s0,
        input logic signed [DATA_W-1:0] s1,
        input logic [7:0]               frac
    );
        logic signed [DATA_W:0]   diff;
        logic signed [DATA_W+9:0] prod;
        diff = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
        prod = diff * $signed({1'b0, frac});
        return s0 + DATA_W'(prod >>> 8);
    endfunction
`endif

    logic [2:0]               r_state;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [15:0]              r_phase;
    logic signed [DATA_W-1:0] r_dry;
    logic signed [DATA_W-1:0] r_s0;
    logic signed [DATA_W-1:0] r_sample_out;
    logic                     r_out_valid;
    logic                     r_overrun;
    logic [ADDR_W-1:0]        r_ram_ada;
    logic signed [DATA_W-1:0] r_ram_din;
    logic                     r_ram_cea;
    logic [ADDR_W-1:0]        r_ram_adb;
    logic                     r_ram_ceb;
    logic                     r_ram_oce;
`ifdef CHORUS_INTERP_EN
    logic signed [DATA_W-1:0] r_s1;
    logic [ADDR_W-1:0]        r_rd1;
    logic [7:0]               r_frac;
`endif

    logic [15:0]              w_tri;
    logic [7:0]               w_tri8;
    logic [15:0]              w_m;
    logic [ADDR_W-1:0]        w_delay;
    logic [ADDR_W-1:0]        w_rd0;
    logic signed [DATA_W-1:0] w_wet;
    logic                     w_accept;

    // Triangle LFO from the pre-update phase, scaled by depth into integer and fractional delay.
    assign w_tri    = r_phase[15] ? {~r_phase[14:0], 1'b0} : {r_phase[14:0], 1'b0};
    assign w_tri8   = 8'(w_tri >> 8);
    assign w_m      = {8'd0, w_tri8} * {8'd0, bus.depth};
    assign w_delay  = ADDR_W'(BASE_DELAY) + ADDR_W'(w_m >> 8);
    assign w_rd0    = r_wr_ptr - w_delay;
    assign w_accept = (r_state == S_IDLE) && bus.sample_valid;

`ifdef CHORUS_INTERP_EN
    assign w_wet = interp(r_s0, r_s1, r_frac);
`else
    assign w_wet = r_s0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_phase      <= '0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
            r_ram_ada    <= '0;
            r_ram_din    <= '0;
            r_ram_cea    <= 1'b0;
            r_ram_adb    <= '0;
            r_ram_ceb    <= 1'b0;
            r_ram_oce    <= 1'b0;
        end else begin
            r_ram_oce   <= 1'b1;
            r_out_valid <= 1'b0;
            r_ram_cea   <= 1'b0;
            r_ram_ceb   <= 1'b0;
            r_overrun   <= bus.sample_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.sample_valid) begin
                        r_phase   <= r_phase + bus.lfo_step;
                        r_ram_cea <= 1'b1;
                        r_ram_ada <= r_wr_ptr;
                        r_ram_din <= bus.sample_in;
                        r_ram_ceb <= 1'b1;
                        r_ram_adb <= w_rd0;
                        r_state   <= S_RD0;
                    end
                end
                S_RD0:  r_state <= S_CAP0;
`ifdef CHORUS_INTERP_EN
                S_CAP0: begin
                    r_ram_ceb <= 1'b1;
                    r_ram_adb <= r_rd1;
                    r_state   <= S_RD1;
                end
                S_RD1:  r_state <= S_CAP1;
                S_CAP1: r_state <= S_MIX;
`else
                S_CAP0: r_state <= S_MIX;
`endif
                S_MIX: begin
                    r_sample_out <= mix_out(bus.enable, r_dry, w_wet);
                    r_out_valid  <= 1'b1;
                    r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sample and tap holding registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dry <= bus.sample_in;
`ifdef CHORUS_INTERP_EN
            r_rd1  <= w_rd0 - ADDR_W'(1);
            r_frac <= w_m[7:0];
`endif
        end
        if (r_state == S_CAP0) r_s0 <= bus.ram_dout;
`ifdef CHORUS_INTERP_EN
        if (r_state == S_CAP1) r_s1 <= bus.ram_dout;
`endif
    end

    assign bus.sample_out = r_sample_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.overrun    = r_overrun;
    assign bus.ram_ada    = r_ram_ada;
    assign bus.ram_din    = r_ram_din;
    assign bus.ram_cea    = r_ram_cea;
    assign bus.ram_adb    = r_ram_adb;
    assign bus.ram_ceb    = r_ram_ceb;
    assign bus.ram_oce    = r_ram_oce;
    assign bus.ram_reset  = ~rst_n;
endmodule
